// File: rtl/pipelined_rca.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipelined_rca                                                  |
// | Purpose : N-bit add/subtract split into STAGES ripple-carry chunks of    |
// |           CHUNK = N/STAGES bits. The carry between chunks is registered, |
// |           so chunk k is added in pipeline stage k. Operand chunks are    |
// |           delayed on the way in and result chunks on the way out, so the |
// |           whole result emerges together after STAGES cycles. The         |
// |           pipeline advances as one unit under a valid/ready handshake.   |
// | Option  : define RCA_FLAGS_EN to add the ovf/zero flag outputs.          |
// | Ports   : clk, rst_n (async, active low)                                 |
// |           in_valid/in_ready, operand_a, operand_b, sub : input side      |
// |           out_valid/out_ready, sum, cout               : output side     |
// |           ovf, zero (RCA_FLAGS_EN only)                : result flags    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pipelined_rca #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] operand_a,
    input  logic [N-1:0] operand_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef RCA_FLAGS_EN
    ,
    output logic         ovf,
    output logic         zero
`endif
);

    localparam int c_CHUNK = N / STAGES;

    // Whole pipeline moves together: it may shift whenever the last stage is
    // empty or its result is being taken this cycle.
    logic w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unconsumed when entering stage k (upper part only;
        // chunks already added are dropped rather than carried along).
        localparam int c_OPW = N - k * c_CHUNK;
        // Result bits known after stage k (chunks 0..k).
        localparam int c_RW  = (k + 1) * c_CHUNK;

        logic [c_OPW-1:0]   w_a_in;
        logic [c_OPW-1:0]   w_b_in;
        logic               w_cin;
        logic               w_vld_in;
        logic               w_load;
        logic [c_CHUNK:0]   w_chunk;
        logic [c_RW-1:0]    w_res_nxt;

        logic               r_vld;
        logic               r_c;
        logic [c_RW-1:0]    r_res;

        if (k == 0) begin : g_head
            // Subtraction is folded in here: b is inverted and the carry-in
            // becomes 1, so no op bit travels down the pipeline.
            assign w_a_in    = operand_a;
            assign w_b_in    = operand_b ^ {N{sub}};
            assign w_cin     = sub;
            assign w_vld_in  = in_valid;
            // Bubbles leave data registers untouched at the entry stage.
            assign w_load    = in_valid;
            assign w_res_nxt = w_chunk[c_CHUNK-1:0];
        end else begin : g_body
            assign w_a_in    = g_stage[k-1].g_fwd.r_a;
            assign w_b_in    = g_stage[k-1].g_fwd.r_b;
            assign w_cin     = g_stage[k-1].r_c;
            assign w_vld_in  = g_stage[k-1].r_vld;
            assign w_load    = 1'b1;
            assign w_res_nxt = {w_chunk[c_CHUNK-1:0], g_stage[k-1].r_res};
        end

        assign w_chunk = {1'b0, w_a_in[c_CHUNK-1:0]}
                       + {1'b0, w_b_in[c_CHUNK-1:0]}
                       + {{c_CHUNK{1'b0}}, w_cin};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_res <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld_in;
                if (w_load) begin
                    r_c   <= w_chunk[c_CHUNK];
                    r_res <= w_res_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [c_OPW-c_CHUNK-1:0] r_a;
            logic [c_OPW-c_CHUNK-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv && w_load) begin
                    r_a <= w_a_in[c_OPW-1:c_CHUNK];
                    r_b <= w_b_in[c_OPW-1:c_CHUNK];
                end
            end
        end

`ifdef RCA_FLAGS_EN
        if (k == STAGES - 1) begin : g_flags
            logic w_c_msb;
            logic r_ovf;
            logic r_zero;

            // Carry into bit N-1 recovered from that bit's sum: s = a ^ b ^ c.
            assign w_c_msb = w_a_in[c_CHUNK-1] ^ w_b_in[c_CHUNK-1] ^ w_chunk[c_CHUNK-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv && w_load) begin
                    r_ovf  <= w_c_msb ^ w_chunk[c_CHUNK];
                    r_zero <= (w_res_nxt == '0);
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].r_vld;
    assign sum       = g_stage[STAGES-1].r_res;
    assign cout      = g_stage[STAGES-1].r_c;
    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;

`ifdef RCA_FLAGS_EN
    assign ovf  = g_stage[STAGES-1].g_flags.r_ovf;
    assign zero = g_stage[STAGES-1].g_flags.r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_rca.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pipelined_rca                                               |
// | Purpose : Directed self-checking bench for pipelined_rca (N=32,          |
// |           STAGES=4): reset, single ops with latency, carries, subtract,  |
// |           back-pressure, full throughput and mid-flight reset.           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_pipelined_rca;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] operand_a;
    logic [N-1:0] operand_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
`ifdef RCA_FLAGS_EN
    logic         ovf;
    logic         zero;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_rca #(.N(N), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef RCA_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated op: transfer, then result expected exactly 4 cycles later.
    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] esum, input logic ecout,
                          input logic eovf, input logic ezero);
        string t;
        t = $sformatf("%s[ovf=%0b,zero=%0b]", tag, eovf, ezero);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        sub       = s;
        tick();
        in_valid  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        sub       = 1'b0;
        tick();
        tick();
        chk({t, "/early"}, 64'(out_valid), 64'd0);
        tick();
        chk({t, "/valid"}, 64'(out_valid), 64'd1);
        chk({t, "/sum"},   64'(sum),       64'(esum));
        chk({t, "/cout"},  64'(cout),      64'(ecout));
`ifdef RCA_FLAGS_EN
        chk({t, "/ovf"},   64'(ovf),       64'(eovf));
        chk({t, "/zero"},  64'(zero),      64'(ezero));
`endif
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int got;
        int first_cyc;
        int last_cyc;
        int seen;
        logic [32:0] q[$];
        logic [32:0] e;

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operand_a = '0;
        operand_b = '0;
        sub       = 1'b0;
        tick();
        tick();
        chk("reset/out_valid", 64'(out_valid), 64'd0);
        chk("reset/sum",       64'(sum),       64'd0);
        chk("reset/cout",      64'(cout),      64'd0);
        chk("reset/in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        tick();

        // ---------------- directed single ops ----------------
        single("add5+3",      32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        single("chunkcarry",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        single("wrap",        32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single("sub3-5",      32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        single("ovfadd",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        single("sub5-3",      32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        single("ovfsub",      32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // ---------------- back-pressure: stall output cycles 5..9 ----------------
        issued = 0;
        got    = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 9);
            in_valid  = (issued < 8);
            operand_a = 32'(issued);
            operand_b = 32'(issued);
            sub       = 1'b0;
            #1;
            if (cyc >= 5 && cyc <= 9) begin
                chk("bp/in_ready_stall", 64'(in_ready), 64'd0);
                chk("bp/held_result", 64'({out_valid, cout, sum}), 64'({1'b1, 1'b0, 32'd2}));
            end
            if (in_valid && in_ready) issued++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp/result%0d", got), 64'({cout, sum}), 64'(2 * got));
                got++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp/count", 64'(got), 64'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // ---------------- full throughput, random operands ----------------
        issued    = 0;
        got       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
            in_valid  = (issued < 100);
            operand_a = $urandom;
            operand_b = $urandom;
            sub       = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                q.push_back({1'b0, operand_a} + {1'b0, operand_b ^ {N{sub}}} + 33'(sub));
                issued++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("thru/spurious", 64'd1, 64'(q.size()));
                end else begin
                    e = q.pop_front();
                    chk($sformatf("thru/res%0d", got), 64'({cout, sum}), 64'(e));
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            @(posedge clk);
            #1;
        end
        chk("thru/count",      64'(got),       64'd100);
        chk("thru/first_cycle", 64'(first_cyc), 64'd4);
        chk("thru/last_cycle",  64'(last_cyc),  64'd103);
        in_valid = 1'b0;
        tick();

        // ---------------- reset mid-flight ----------------
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            operand_a = 32'hFFFF_FFFF;
            operand_b = 32'(i + 2);
            sub       = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("midrst/pre_valid", 64'({out_valid, cout, sum}), 64'({1'b1, 1'b1, 32'd1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst/out_valid", 64'(out_valid), 64'd0);
        chk("midrst/sum",       64'(sum),       64'd0);
        chk("midrst/cout",      64'(cout),      64'd0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst/no_stale", 64'(seen), 64'd0);
        single("postrst", 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
